// File: rtl/fsk_frame_sync.sv
// Frame synchroniser behind the FSK demodulator. It takes one bit per symbol window and
// hunts for the sync word. After sync it deserialises a fixed-length payload into bytes, MSB first.
module fsk_frame_sync #(
  parameter int          WIN_LEN     = 16,
  parameter int          SYNC_LEN    = 16,
  parameter logic [15:0] SYNC_WORD   = 16'hEB90,
  parameter int          FRAME_BYTES = 4
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       sig_enable,
  input  logic       sig_reb,
  output logic       bit_strobe,
  output logic       frame_sync,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_done
);

  localparam int PH_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam int HC_W = $clog2(SYNC_LEN + 1);
  localparam logic [PH_W-1:0]     PH_LAST   = PH_W'(WIN_LEN - 1);
  localparam logic [HC_W-1:0]     HC_FULL   = HC_W'(SYNC_LEN);
  localparam logic [SYNC_LEN-1:0] SYNC_PAT  = SYNC_WORD[SYNC_LEN-1:0];
  localparam logic [7:0]          LAST_BYTE = 8'(FRAME_BYTES);

  typedef enum logic {HUNT, RECV} state_t;

  state_t              state_q, state_d;
  logic [PH_W-1:0]     phase;
  logic                win_seen;
  logic [SYNC_LEN-1:0] sync_sr, sync_nxt;
  logic [HC_W-1:0]     hunt_cnt, hunt_nxt;
  logic [6:0]          byte_sr;
  logic [7:0]          byte_asm;
  logic [2:0]          bit_cnt;
  logic [7:0]          byte_cnt, byte_cnt_nxt;
  logic                sample_p0, sync_hit, byte_end, frame_end;

  // p0: sample decision and next-state evaluation on the window boundary
  assign sample_p0    = sig_enable && (phase == '0) && win_seen;
  assign sync_nxt     = SYNC_LEN'({sync_sr, sig_reb});
  assign hunt_nxt     = (hunt_cnt == HC_FULL) ? hunt_cnt : HC_W'(hunt_cnt + 1'b1);
  assign byte_asm     = {byte_sr, sig_reb};
  assign byte_cnt_nxt = byte_cnt + 8'd1;
  assign frame_sync   = (state_q == RECV);

  always_comb begin
    state_d   = state_q;
    sync_hit  = 1'b0;
    byte_end  = 1'b0;
    frame_end = 1'b0;
    if (!sig_enable) begin
      state_d = HUNT;
    end else if (sample_p0) begin
      case (state_q)
        HUNT: begin
          if (hunt_nxt == HC_FULL && sync_nxt == SYNC_PAT) begin
            sync_hit = 1'b1;
            state_d  = RECV;
          end
        end
        RECV: begin
          if (bit_cnt == 3'd7) begin
            byte_end = 1'b1;
            if (byte_cnt_nxt == LAST_BYTE) begin
              frame_end = 1'b1;
              state_d   = HUNT;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) state_q <= HUNT;
    else        state_q <= state_d;
  end

  // The first window after enable rises is only used to align the phase, so it yields no sample.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      phase    <= '0;
      win_seen <= 1'b0;
    end else if (!sig_enable) begin
      phase    <= '0;
      win_seen <= 1'b0;
    end else if (phase == PH_LAST) begin
      phase    <= '0;
      win_seen <= 1'b1;
    end else begin
      phase    <= phase + 1'b1;
    end
  end

  // p1: registered strobes and the shift/deserialise state
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      bit_strobe <= 1'b0;
      data_valid <= 1'b0;
      frame_done <= 1'b0;
      data_out   <= '0;
      sync_sr    <= '0;
      hunt_cnt   <= '0;
      byte_sr    <= '0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
    end else begin
      bit_strobe <= sample_p0;
      data_valid <= byte_end;
      frame_done <= frame_end;
      if (!sig_enable) begin
        sync_sr  <= '0;
        hunt_cnt <= '0;
        byte_sr  <= '0;
        bit_cnt  <= '0;
        byte_cnt <= '0;
      end else if (sample_p0) begin
        if (state_q == HUNT) begin
          sync_sr  <= sync_nxt;
          hunt_cnt <= hunt_nxt;
          if (sync_hit) begin
            bit_cnt  <= '0;
            byte_cnt <= '0;
          end
        end else begin
          byte_sr <= byte_asm[6:0];
          bit_cnt <= bit_cnt + 3'd1;
          if (byte_end) begin
            data_out <= byte_asm;
            byte_cnt <= byte_cnt_nxt;
          end
          // Each frame must be preceded by a full, fresh sync word.
          if (frame_end) begin
            sync_sr  <= '0;
            hunt_cnt <= '0;
          end
        end
      end
    end
  end

endmodule
